// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the round-robin encoder arbiter.
// Imported by rr_pick and rr_encoder_arbiter.
package rr_encoder_arbiter_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Index k maps to request line k, so the one-hot form is simply bit k set.
    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of elig at or above ptr, wrapping 7 -> 0.
module rr_pick
    import rr_encoder_arbiter_pkg::*;
(
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;

    // Rotate so ptr lands on bit 0; the 3-bit add wraps the index for free.
    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N; j++) begin
            w_rot[j] = elig[ptr + IDX_W'(j)];
        end
    end

    // Descending scan leaves the lowest set offset as the final assignment.
    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                found = 1'b1;
                w_off = IDX_W'(j);
            end
        end
    end

    assign idx = ptr + w_off;

endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter for 8 requesters with registered one-hot and binary grants.
// A grant is held until its owner releases or MAX_HOLD cycles elapse.
module rr_encoder_arbiter
    import rr_encoder_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    logic             r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [N-1:0]     r_blk;
    logic [N-1:0]     r_gnt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic             r_gnt_valid;
    logic             r_timeout;

    logic [N-1:0]     w_elig;
    logic             w_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_busy;
    logic             w_release;
    logic             w_expire;
    logic [N-1:0]     w_blk_next;

    assign w_elig = req & ~r_blk;

    rr_pick u_pick (
        .elig  (w_elig),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_pick_idx)
    );

    assign w_busy     = (r_state == ST_BUSY);
    assign w_release  = w_busy && !req[r_gnt_idx];
    assign w_expire   = w_busy && req[r_gnt_idx] && (MAX_HOLD != 0)
                        && (r_hold_cnt == CNT_W'(MAX_HOLD));
    // A blocked requester is freed by any cycle with its request low.
    assign w_blk_next = (r_blk & req) | (w_expire ? onehot(r_gnt_idx) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_blk       <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            r_blk     <= w_blk_next;
            if (r_state == ST_IDLE) begin
                if (w_found) begin
                    r_gnt       <= onehot(w_pick_idx);
                    r_gnt_idx   <= w_pick_idx;
                    r_gnt_valid <= 1'b1;
                    r_hold_cnt  <= CNT_W'(1);
                    r_state     <= ST_BUSY;
                end
            end else begin
                if (w_release || w_expire) begin
                    r_gnt       <= '0;
                    r_gnt_valid <= 1'b0;
                    r_ptr       <= r_gnt_idx + IDX_W'(1);
                    r_state     <= ST_IDLE;
                end else begin
                    r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Scoreboard bench for rr_encoder_arbiter: directed scenarios then random traffic,
// checked against a behavioural owner/pointer model.
module tb_rr_encoder_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gntIdx;
    logic       gntValid;
    logic       timeoutPulse;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       tout;
    } exp_t;

    exp_t expQ[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   cycleNo     = 0;
    bit   started     = 1'b0;

    int mOwner   = -1;
    int mHold    = 0;
    int mPtr     = 0;
    int mLastIdx = 0;
    bit mTout    = 1'b0;
    bit mBlocked[8];

    rr_encoder_arbiter #(.MAX_HOLD(MAXH), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gntIdx),
        .gnt_valid (gntValid),
        .timeout   (timeoutPulse)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how long, and where the search resumes.
    task automatic modelStep(input logic [7:0] r, input logic rs);
        bit newBlocked[8];
        if (rs) begin
            mOwner = -1; mHold = 0; mPtr = 0; mLastIdx = 0; mTout = 1'b0;
            for (int k = 0; k < 8; k++) mBlocked[k] = 1'b0;
        end else begin
            mTout = 1'b0;
            for (int k = 0; k < 8; k++) newBlocked[k] = mBlocked[k] && r[k];
            if (mOwner < 0) begin
                for (int i = 0; i < 8; i++) begin
                    int c;
                    c = (mPtr + i) % 8;
                    if (r[c] && !mBlocked[c]) begin
                        mOwner = c; mLastIdx = c; mHold = 1;
                        break;
                    end
                end
            end else if (!r[mOwner]) begin
                mPtr = (mOwner + 1) % 8;
                mOwner = -1;
            end else if (MAXH != 0 && mHold == MAXH) begin
                mTout = 1'b1;
                newBlocked[mOwner] = 1'b1;
                mPtr = (mOwner + 1) % 8;
                mOwner = -1;
            end else begin
                mHold++;
            end
            for (int k = 0; k < 8; k++) mBlocked[k] = newBlocked[k];
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic rs);
        exp_t e;
        @(negedge clk);
        req = r;
        rst = rs;
        modelStep(r, rs);
        e.gnt   = (mOwner >= 0) ? (8'h01 << mOwner) : 8'h00;
        e.idx   = 3'(mLastIdx);
        e.valid = (mOwner >= 0);
        e.tout  = mTout;
        expQ.push_back(e);
        started = 1'b1;
    endtask

    task automatic checkOutput(input exp_t e);
        testsRun++;
        if (gnt !== e.gnt || gntIdx !== e.idx || gntValid !== e.valid || timeoutPulse !== e.tout) begin
            testsFailed++;
            $display("[TB] FAIL cycle %0d outputs: got gnt=%h idx=%0d valid=%b timeout=%b, required gnt=%h idx=%0d valid=%b timeout=%b",
                     cycleNo, gnt, gntIdx, gntValid, timeoutPulse, e.gnt, e.idx, e.valid, e.tout);
        end
    endtask

    // Monitor: one expected entry is due after every active edge once stimulus starts.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycleNo++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end else if (started) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL cycle %0d scoreboard: got empty queue, required one entry", cycleNo);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] r;
        logic       rs;

        // Reset with all requests high, then first grant to 0.
        repeat (3) applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'hFF, 1'b0);
        repeat (2) applyStimulus(8'h00, 1'b0);

        // Single requester 5, then wrap with 0 and 3 pending.
        applyStimulus(8'h00, 1'b1);
        repeat (4) applyStimulus(8'h20, 1'b0);
        repeat (2) applyStimulus(8'h00, 1'b0);
        repeat (3) applyStimulus(8'h09, 1'b0);
        repeat (4) applyStimulus(8'h08, 1'b0);
        repeat (2) applyStimulus(8'h00, 1'b0);

        // Rotation: everyone requests, owners drop after two grant cycles.
        applyStimulus(8'hFF, 1'b1);
        for (int c = 0; c < 30; c++) begin
            r = 8'hFF;
            if (mOwner >= 0 && mHold == 2) r[mOwner] = 1'b0;
            applyStimulus(r, 1'b0);
        end

        // Timeout: 2 holds forever, 7 joins later; both get revoked and blocked.
        applyStimulus(8'h00, 1'b1);
        repeat (2) applyStimulus(8'h04, 1'b0);
        repeat (14) applyStimulus(8'h84, 1'b0);
        applyStimulus(8'h00, 1'b0);
        repeat (3) applyStimulus(8'h04, 1'b0);
        repeat (2) applyStimulus(8'h00, 1'b0);

        // Reset mid-grant to 3, then regrant.
        repeat (3) applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h08, 1'b1);
        repeat (3) applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h00, 1'b0);

        // Random traffic with occasional releases and resets.
        r = 8'h00;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            if (mOwner >= 0 && $urandom_range(0, 4) == 0) r[mOwner] = 1'b0;
            rs = ($urandom_range(0, 79) == 0);
            applyStimulus(r, rs);
        end

        @(posedge clk);
        #3;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: got %0d pending entries, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
